// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_ctrl
// Description : Multiplexed-bus cycle sequencer (T1/T2/TW/T3) with programmable
//               wait states and READY stretching. Optional macro BUS_TIMEOUT_EN
//               adds a READY-stall abort with an err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_ctrl #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int WW      = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [1:0]           req_type,
   input  logic                 req_fetch,
   input  logic [AW-1:0]        req_addr,
   input  logic [DW-1:0]        req_wdata,
   input  logic [WW-1:0]        wait_cfg,
   input  logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [DW-1:0]        rdata,
   output logic [AW-DW-1:0]     haddress,
   output logic [DW-1:0]        ad_out,
   output logic                 ad_oe,
   input  logic [DW-1:0]        ad_in,
   output logic                 ALE,
   output logic                 RDn,
   output logic                 WRn,
   output logic                 IOMn,
   output logic                 S1,
   output logic                 S0
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_TW   = 3'd3,
      S_T3   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [AW-DW-1:0]  haddr_q, haddr_d;
   logic [DW-1:0]     adout_q, adout_d;
   logic              adoe_q, adoe_d, ale_q, ale_d;
   logic              rdn_q, rdn_d, wrn_q, wrn_d, iomn_q, iomn_d;
   logic [1:0]        stat_q, stat_d;
   logic              wr_q, wr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic              abort;

`ifdef BUS_TIMEOUT_EN
   localparam int            SW        = $clog2(TIMEOUT + 2);
   localparam logic [SW-1:0] C_TIMEOUT = SW'(TIMEOUT);
   logic [SW-1:0] stall_q, stall_d;
   logic          err_q, err_d;
   assign abort = (state_q == S_TW) && (stall_q == C_TIMEOUT);
   assign err   = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign abort = 1'b0;
   assign err   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rdata_d = rdata_q;
      haddr_d = haddr_q;
      adout_d = adout_q;
      adoe_d  = adoe_q;
      ale_d   = ale_q;
      rdn_d   = rdn_q;
      wrn_d   = wrn_q;
      iomn_d  = iomn_q;
      stat_d  = stat_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      wcnt_d  = wcnt_q;
`ifdef BUS_TIMEOUT_EN
      stall_d = stall_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_T1;
               busy_d  = 1'b1;
               wr_d    = req_type[0];
               wdata_d = req_wdata;
               wcnt_d  = wait_cfg;
               ale_d   = 1'b1;
               adout_d = req_addr[DW-1:0];
               adoe_d  = 1'b1;
               haddr_d = req_addr[AW-1:DW];
               iomn_d  = req_type[1];
               // Fetch status only qualifies a memory read.
               if (req_fetch && (req_type == 2'b00)) stat_d = 2'b11;
               else if (req_type[0])                 stat_d = 2'b01;
               else                                  stat_d = 2'b10;
`ifdef BUS_TIMEOUT_EN
               stall_d = '0;
`endif
            end
         end
         S_T1: begin
            state_d = S_T2;
            ale_d   = 1'b0;
            if (wr_q) begin
               wrn_d   = 1'b0;
               adout_d = wdata_q;
               adoe_d  = 1'b1;
            end else begin
               rdn_d   = 1'b0;
               adoe_d  = 1'b0;
            end
         end
         S_T2, S_TW: begin
            if (abort) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               rdn_d   = 1'b1;
               wrn_d   = 1'b1;
               adoe_d  = 1'b0;
               iomn_d  = 1'b0;
               stat_d  = 2'b00;
               if (!wr_q) rdata_d = '1;
`ifdef BUS_TIMEOUT_EN
               err_d   = 1'b1;
`endif
            end else if (wcnt_q != '0) begin
               state_d = S_TW;
               wcnt_d  = wcnt_q - WW'(1);
            end else if (!ready) begin
               state_d = S_TW;
`ifdef BUS_TIMEOUT_EN
               stall_d = stall_q + SW'(1);
`endif
            end else begin
               state_d = S_T3;
            end
         end
         S_T3: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rdn_d   = 1'b1;
            wrn_d   = 1'b1;
            adoe_d  = 1'b0;
            iomn_d  = 1'b0;
            stat_d  = 2'b00;
            if (!wr_q) rdata_d = ad_in;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         haddr_q <= '0;
         adout_q <= '0;
         adoe_q  <= 1'b0;
         ale_q   <= 1'b0;
         rdn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         iomn_q  <= 1'b0;
         stat_q  <= 2'b00;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         wcnt_q  <= '0;
`ifdef BUS_TIMEOUT_EN
         stall_q <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         haddr_q <= haddr_d;
         adout_q <= adout_d;
         adoe_q  <= adoe_d;
         ale_q   <= ale_d;
         rdn_q   <= rdn_d;
         wrn_q   <= wrn_d;
         iomn_q  <= iomn_d;
         stat_q  <= stat_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         wcnt_q  <= wcnt_d;
`ifdef BUS_TIMEOUT_EN
         stall_q <= stall_d;
         err_q   <= err_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign haddress = haddr_q;
   assign ad_out   = adout_q;
   assign ad_oe    = adoe_q;
   assign ALE      = ale_q;
   assign RDn      = rdn_q;
   assign WRn      = wrn_q;
   assign IOMn     = iomn_q;
   assign S1       = stat_q[1];
   assign S0       = stat_q[0];

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_ctrl
// Description : Self-checking bench for bus_cycle_ctrl: transaction-level model
//               compared every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_ctrl;
   localparam int TIMEOUT = 15;
`ifdef BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, req = 1'b0, req_fetch = 1'b0, ready = 1'b1;
   logic [1:0] req_type = 2'b00;
   logic [15:0] req_addr = '0;
   logic [7:0] req_wdata = '0, ad_in = '0;
   logic [2:0] wait_cfg = '0;
   logic       busy, done, err, ad_oe, ALE, RDn, WRn, IOMn, S1, S0;
   logic [7:0] rdata, haddress, ad_out;

   bus_cycle_ctrl #(.AW(16), .DW(8), .WW(3), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_fetch(req_fetch),
      .req_addr(req_addr), .req_wdata(req_wdata), .wait_cfg(wait_cfg), .ready(ready),
      .busy(busy), .done(done), .err(err), .rdata(rdata), .haddress(haddress),
      .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .ALE(ALE), .RDn(RDn), .WRn(WRn),
      .IOMn(IOMn), .S1(S1), .S0(S0)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: age counts cycles since accept (1 = address phase),
   // m_last marks the final strobe cycle before completion.
   bit        m_busy, m_done, m_err, m_last, m_wr, m_io, m_fetch;
   int        m_age, m_extra, m_stalls;
   logic [7:0] m_rdata, m_hadr, m_adout, m_wdata;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_err <= 0; m_last <= 0; m_wr <= 0; m_io <= 0;
         m_fetch <= 0; m_age <= 0; m_extra <= 0; m_stalls <= 0;
         m_rdata <= '0; m_hadr <= '0; m_adout <= '0; m_wdata <= '0;
      end else begin
         m_done <= 0;
         m_err  <= 0;
         if (!m_busy) begin
            if (req) begin
               m_busy <= 1; m_age <= 1; m_last <= 0; m_stalls <= 0;
               m_extra <= int'(wait_cfg);
               m_wr <= req_type[0]; m_io <= req_type[1];
               m_fetch <= req_fetch && (req_type == 2'b00);
               m_hadr <= req_addr[15:8]; m_adout <= req_addr[7:0];
               m_wdata <= req_wdata;
            end
         end else if (m_age == 1) begin
            m_age <= 2;
            if (m_wr) m_adout <= m_wdata;
         end else if (m_last) begin
            m_busy <= 0; m_done <= 1;
            if (!m_wr) m_rdata <= ad_in;
         end else if (TO_EN && TIMEOUT > 0 && m_stalls == TIMEOUT) begin
            m_busy <= 0; m_err <= 1;
            if (!m_wr) m_rdata <= 8'hFF;
         end else begin
            m_age <= m_age + 1;
            if (m_extra > 0)  m_extra <= m_extra - 1;
            else if (!ready)  m_stalls <= m_stalls + 1;
            else              m_last <= 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("ALE", ALE, m_busy && m_age == 1);
         chk("RDn", RDn, !(m_busy && m_age >= 2 && !m_wr));
         chk("WRn", WRn, !(m_busy && m_age >= 2 && m_wr));
         chk("ad_oe", ad_oe, m_busy && (m_age == 1 || m_wr));
         chk("IOMn", IOMn, m_busy && m_io);
         chk("S1S0", {S1, S0}, !m_busy ? 2'd0 : (m_fetch ? 2'd3 : (m_wr ? 2'd1 : 2'd2)));
         chk("ad_out", ad_out, m_adout);
         chk("haddress", haddress, m_hadr);
         chk("rdata", rdata, m_rdata);
      end
   end

   logic [7:0] t1_adout, t1_hadr;
   logic       t1_ale, t1_iomn;
   logic [1:0] t1_s;

   // Called at posedge+1 with the DUT idle; returns the done latency in cycles.
   task automatic run_txn(input logic [1:0] ty, input bit fe, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [2:0] wc, input int rlow,
                          input bit hold, output int lat, output int rdl, output int wrl,
                          output bit bad_ad, output int ale_extra);
      lat = -1; rdl = 0; wrl = 0; bad_ad = 0; ale_extra = 0;
      req_type = ty; req_fetch = fe; req_addr = addr; req_wdata = wd; wait_cfg = wc;
      ready = 1'b1; req = 1'b1;
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      @(negedge clk);
      t1_ale = ALE; t1_adout = ad_out; t1_hadr = haddress; t1_iomn = IOMn; t1_s = {S1, S0};
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         ready = (k > rlow);
         @(negedge clk);
         if (!RDn) rdl++;
         if (!WRn) begin wrl++; if (ad_out !== wd) bad_ad = 1; end
         if (ALE) ale_extra++;
         if (done) begin lat = k; break; end
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      req = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      chk("idle_reached", ok, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int lat, rdl, wrl, alex, last_ale, accepts, dones, cnt, errk, errcnt;
   bit bad_ad, prev_ale, consec;

   initial begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_RDn", RDn, 1);
      chk("rst_WRn", WRn, 1);
      chk("rst_ad_oe", ad_oe, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Memory read, no waits
      ad_in = 8'hA5;
      run_txn(2'b00, 0, 16'h2050, 8'h00, 3'd0, 0, 0, lat, rdl, wrl, bad_ad, alex);
      chk("rd_t1_ALE", t1_ale, 1);
      chk("rd_t1_adout", t1_adout, 8'h50);
      chk("rd_t1_haddr", t1_hadr, 8'h20);
      chk("rd_t1_S", t1_s, 2'b10);
      chk("rd_t1_IOMn", t1_iomn, 0);
      chk("rd_RDn_cycles", rdl, 2);
      chk("rd_latency", lat, 3);
      chk("rd_rdata", rdata, 8'hA5);
      wait_idle();

      // IO write, two programmed waits
      run_txn(2'b11, 0, 16'h0042, 8'h3C, 3'd2, 0, 0, lat, rdl, wrl, bad_ad, alex);
      chk("iow_IOMn", t1_iomn, 1);
      chk("iow_S", t1_s, 2'b01);
      chk("iow_WRn_cycles", wrl, 4);
      chk("iow_data_held", bad_ad, 0);
      chk("iow_latency", lat, 5);
      chk("iow_rdata_kept", rdata, 8'hA5);
      wait_idle();

      // Opcode fetch, READY low for 4 cycles, second req held throughout
      ad_in = 8'h5E;
      run_txn(2'b00, 1, 16'h1234, 8'h00, 3'd0, 4, 1, lat, rdl, wrl, bad_ad, alex);
      chk("fetch_S", t1_s, 2'b11);
      chk("fetch_latency", lat, 7);
      chk("fetch_no_early_accept", alex, 0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk("fetch_second_accept", ALE, 1);
      wait_idle();

      // Reset during TW of a write
      req_type = 2'b01; req_fetch = 0; req_addr = 16'h7788; req_wdata = 8'h99;
      wait_cfg = 3'd5; ready = 1'b1; req = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("mrst_WRn", WRn, 1);
      chk("mrst_ad_oe", ad_oe, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("mrst_no_done", done, 0);
      @(posedge clk); #1;
      ad_in = 8'h77;
      run_txn(2'b00, 0, 16'hBEEF, 8'h00, 3'd0, 0, 0, lat, rdl, wrl, bad_ad, alex);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_rdata", rdata, 8'h77);
      wait_idle();

      // Back-to-back with req held
      wait_cfg = 3'd0; ready = 1'b1; req = 1'b1;
      last_ale = -1; accepts = 0; dones = 0; prev_ale = 0; consec = 0;
      for (int k = 0; k < 40; k++) begin
         req_type = 2'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
         req_fetch = 1'($urandom); ad_in = 8'($urandom);
         @(negedge clk);
         if (ALE && prev_ale) consec = 1;
         if (ALE) begin
            if (last_ale >= 0) chk("b2b_ale_period", k - last_ale, 4);
            last_ale = k; accepts++;
         end
         if (done) dones++;
         prev_ale = ALE;
         @(posedge clk); #1;
      end
      req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ALE) accepts++;
         if (done) dones++;
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk("b2b_no_consecutive_ale", consec, 0);
      chk("b2b_accept_vs_done", dones, accepts);
      @(posedge clk); #1;

      // Randomised traffic, checked by the model every cycle
      for (int k = 0; k < 400; k++) begin
         req = ($urandom_range(0, 2) == 0);
         req_type = 2'($urandom); req_fetch = 1'($urandom);
         req_addr = 16'($urandom); req_wdata = 8'($urandom);
         wait_cfg = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 3));
         ready = ($urandom_range(0, 3) != 0);
         ad_in = 8'($urandom);
         @(posedge clk); #1;
      end
      ready = 1'b1;
      wait_idle();

      // READY held low
      req_type = 2'b00; req_fetch = 0; req_addr = 16'h4000; wait_cfg = 3'd0;
      req = 1'b1; ready = 1'b0;
      @(posedge clk); #1; req = 1'b0;
`ifdef BUS_TIMEOUT_EN
      errk = -1; errcnt = 0; cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (err) begin errcnt++; if (errk < 0) errk = k; end
         if (done) cnt++;
      end
      chk("to_err_cycle", errk, 17);
      chk("to_err_once", errcnt, 1);
      chk("to_no_done", cnt, 0);
      chk("to_rdata", rdata, 8'hFF);
      chk("to_busy", busy, 0);
      ready = 1'b1;
      @(posedge clk); #1;
`else
      cnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (!busy) cnt++;
         if (err) cnt++;
      end
      chk("stall_busy_100", cnt, 0);
      @(posedge clk); #1;
      ready = 1'b1;
      wait_idle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Parametrised bus-cycle sequencer.
- Converts single-cycle transfer requests from the microcode sequencer into multiplexed-bus timing: T1/T2/TW/T3 states driving ALE, RDn, WRn, IOMn, S1, S0 and the multiplexed address/data lines.
- Replaces the bus-control signals previously driven straight from the testbench.
- Adds programmable wait states, READY handling and configurable address/data widths.

Parameters:
- AW, 16: total address width.
- DW, 8: multiplexed low address/data width; haddress width is AW-DW.
- WW, 3: width of the wait_cfg input (maximum programmed wait states = 2^WW-1).
- TIMEOUT, 15: maximum READY-stall cycles before abort. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  transfer request; accepted only while busy=0.
- req_type  in  2  00 mem read, 01 mem write, 10 io read, 11 io write.
- req_fetch  in  1  opcode fetch qualifier; honoured only with req_type=00.
- req_addr  in  AW  transfer address.
- req_wdata  in  DW  write data.
- wait_cfg  in  WW  minimum wait states for this cycle; sampled at accept.
- ready  in  1  external READY; low stretches the cycle.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse when a cycle completes.
- err  out  1  one-cycle pulse on timeout abort; tied 0 without BUS_TIMEOUT_EN.
- rdata  out  DW  read data; valid when done=1.
- haddress  out  AW-DW  upper address.
- ad_out  out  DW  multiplexed address/data drive value.
- ad_oe  out  1  output enable for ad_out; the top level builds the tristate.
- ad_in  in  DW  multiplexed bus sampled value.
- ALE, RDn, WRn, IOMn, S1, S0  out  1 each  bus strobes and status.

Behaviour:
- All outputs registered.
- Reset values, applied immediately even mid-cycle:
  - state=IDLE, busy=0, done=0, err=0, rdata=0, haddress=0, ad_out=0, ad_oe=0.
  - ALE=0, RDn=1, WRn=1, IOMn=0, S1=0, S0=0.
  - Any in-flight cycle is dropped without done.
- States: IDLE, T1, T2, TW, T3.
- IDLE:
  - If req=1, latch the request fields.
  - Load wait_cnt=wait_cfg.
  - Set busy=1 and go to T1.
  - done is cleared in every state other than the completing transition.
- T1:
  - ALE=1, ad_out=addr[DW-1:0], ad_oe=1, haddress=addr[AW-1:DW].
  - IOMn=req_type[1].
  - S1S0: 11 for fetch, 10 for read, 01 for write.
  - Always go to T2.
- T2:
  - ALE=0.
  - Read: RDn=0, ad_oe=0.
  - Write: WRn=0, ad_out=wdata, ad_oe=1.
- T2/TW transition rule, in priority order:
  1. wait_cnt!=0: go to TW and decrement wait_cnt.
  2. Else ready=0: go to TW.
  3. Else: go to T3.
- TW: holds all T2 outputs.
- T3:
  - Strobes still asserted.
  - On exit edge: rdata<=ad_in for reads.
  - RDn=1, WRn=1, ad_oe=0, S1S0=00, busy=0, done=1, state=IDLE.
  - rdata is unchanged on writes.
- Latency:
  - Accept edge to done = 3 + number of TW cycles.
  - With wait_cfg=0 and ready=1: T1, T2, T3, then done.
- Back-to-back: req sampled in the done cycle is accepted, so the minimum IDLE gap is 1 cycle.
- req while busy=1: ignored and not queued. The requester must hold req until busy rises.
- Request fields are latched at accept; later changes have no effect on the current cycle.
- req_fetch with a write or I/O type is treated as 0.
- haddress holds its last value in IDLE.
- IOMn returns to 0 on exit to IDLE.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A stall counter clears at T1 and increments on each TW cycle entered because ready=0.
  - When the counter reaches TIMEOUT, the next edge aborts: strobes deasserted, ad_oe=0, busy=0.
  - err=1 for one cycle with done=0; rdata is set to all ones for reads.
- Not defined:
  - No counter; ready=0 stalls indefinitely.
  - err is constant 0.

Test Plan:
- Mem read, addr=16'h2050, wait_cfg=0, ready=1, ad_in=8'hA5 in T3:
  - T1: ALE=1, ad_out=8'h50, haddress=8'h20, S1S0=10, IOMn=0.
  - RDn=0 for 2 cycles.
  - done at cycle 3 after accept; rdata=8'hA5.
- IO write, addr=16'h0042, wdata=8'h3C, wait_cfg=2, ready=1:
  - IOMn=1, S1S0=01.
  - ad_out=8'h3C with WRn=0 during T2, TW, TW.
  - done at cycle 5 after accept.
- Opcode fetch with ready low for 4 cycles from T2:
  - S1S0=11.
  - Exactly 4 TW cycles, then T3; done at cycle 7 after accept.
  - A second req held during busy is accepted only in the done cycle.
- Reset asserted during TW of a write:
  - WRn=1, ad_oe=0, busy=0 immediately, no done.
  - After release, a new read completes normally.
- Back-to-back requests with req held continuously:
  - ALE pulses every 4 cycles with wait_cfg=0; never 2 consecutive ALE cycles.
  - Each done is paired with exactly one accept.
- BUS_TIMEOUT_EN, TIMEOUT=15, ready held low:
  - err pulses once after 15 stall cycles; rdata=8'hFF; done never asserts.
  - Without the macro, busy stays 1 for 100 cycles.
